// File: rtl/amiga_dtackgen_pkg.sv
// Shared definitions for the Amiga 68000 bus-cycle terminator: FSM encoding
// and a helper for slicing fields out of packed per-region parameters.
package amiga_dtackgen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_BERR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_ACK  = ST_ACK,
    S_BERR = ST_BERR
  } state_e;

  localparam int FIELD_MAX_W = 256;

  // Returns field idx of width w (w <= 32) from a packed parameter vector.
  function automatic logic [31:0] field_get(input logic [FIELD_MAX_W-1:0] vec,
                                            input int idx, input int w);
    return 32'(vec >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/amiga_dtackgen_if.sv
// CPU-side bus and region-enable signals of the DTACK generator.
interface amiga_dtackgen_if #(
  parameter int NREGIONS = 2,
  parameter int ADDR_W   = 5
);
  logic [ADDR_W-1:0]   A;
  logic                _AS;
  logic                RW;
  logic                _OVR;
  logic                OVL;
  logic                XRDY;
  logic [NREGIONS-1:0] _CE;
  logic                _DTACK;
  logic                _BERR;
  logic                _DOE;

  modport master (
    output A, _AS, RW, _OVR, OVL, XRDY,
    input  _CE, _DTACK, _BERR, _DOE
  );

  modport slave (
    input  A, _AS, RW, _OVR, OVL, XRDY,
    output _CE, _DTACK, _BERR, _DOE
  );
endinterface

// File: rtl/amiga_dtackgen_sync2.sv
// Two-flop synchroniser for an asynchronous strobe; resets to RST_VAL.
module amiga_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/amiga_dtackgen.sv
// Multi-region 68000 bus-cycle terminator: address decode with ROM overlay,
// per-region wait states stretched by XRDY, /DTACK, /DOE and timeout /BERR.
module amiga_dtackgen
  import amiga_dtackgen_pkg::*;
#(
  parameter int                           NREGIONS    = 2,
  parameter int                           ADDR_W      = 5,
  parameter int                           WAIT_W      = 4,
  parameter logic [NREGIONS*ADDR_W-1:0]   REGION_BASE = {5'b11000, 5'b11111},
  parameter logic [NREGIONS*ADDR_W-1:0]   REGION_MASK = '1,
  parameter logic [NREGIONS*WAIT_W-1:0]   REGION_WAIT = {4'd2, 4'd0},
  parameter int                           OVL_REGION  = 0,
  parameter int                           TIMEOUT     = 64
) (
  input  logic             CLK,
  input  logic             _RESET,
  amiga_dtackgen_if.slave  bus
);

  localparam int IDX_W   = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [STALL_W-1:0] TO_LAST = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic                as_s;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [WAIT_W-1:0]   cnt_d;
  logic [NREGIONS-1:0] ce_n_d;

  state_e              state_q;
  logic                rw_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [STALL_W-1:0]  stall_q;
  logic [NREGIONS-1:0] ce_n_q;
  logic                dtack_n_q;
  logic                berr_n_q;
  logic                doe_n_q;

  amiga_sync2 #(.RST_VAL(1'b1)) u_as_sync (
    .clk_i  (CLK),
    .rst_ni (_RESET),
    .d_i    (bus._AS),
    .q_o    (as_s)
  );

  // Scan from the top index down so the lowest matching region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if ((((bus.A ^ ADDR_W'(field_get(FIELD_MAX_W'(REGION_BASE), i, ADDR_W)))
            & ADDR_W'(field_get(FIELD_MAX_W'(REGION_MASK), i, ADDR_W))) == '0) ||
          ((i == OVL_REGION) && bus.OVL && (bus.A == '0))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    cnt_d  = WAIT_W'(field_get(FIELD_MAX_W'(REGION_WAIT), int'(hit_idx), WAIT_W));
    ce_n_d = ~(NREGIONS'(1) << hit_idx);
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      stall_q   <= '0;
      ce_n_q    <= '1;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      doe_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!as_s && hit && bus._OVR) begin
            state_q <= S_WAIT;
            rw_q    <= bus.RW;
            cnt_q   <= cnt_d;
            stall_q <= '0;
            ce_n_q  <= ce_n_d;
          end
        end
        S_WAIT: begin
          if (as_s) begin
            state_q <= S_IDLE;
            ce_n_q  <= '1;
          end else if (bus.XRDY) begin
            if (cnt_q == '0) begin
              state_q   <= S_ACK;
              dtack_n_q <= 1'b0;
              doe_n_q   <= !rw_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else begin
            // Stall count saturates so a disabled timeout can never wrap into a match.
            if (stall_q != '1) stall_q <= stall_q + 1'b1;
            if ((TIMEOUT != 0) && (stall_q == TO_LAST)) begin
              state_q  <= S_BERR;
              berr_n_q <= 1'b0;
            end
          end
        end
        S_ACK, S_BERR: begin
          if (as_s) begin
            state_q   <= S_IDLE;
            ce_n_q    <= '1;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            doe_n_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus._CE    = ce_n_q;
  assign bus._DTACK = dtack_n_q;
  assign bus._BERR  = berr_n_q;
  assign bus._DOE   = doe_n_q;

endmodule
